// File: rtl/egd_bitstream_buffer.sv
// Bitstream feeder for the exp-Golomb decoder: Wishbone word FIFO into a 64-bit
// left-aligned shift register, exposing the next 16 unconsumed bits as a window.
module egd_bitstream_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] win_o,
    output logic        win_valid_o,
    input  logic        consume_en_i,
    input  logic [4:0]  consume_len_i,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [63:0] r_sreg;
    logic [6:0]  r_bit_cnt;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_err;
    logic        r_win_valid;

    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_req;
    logic        w_sel_ctrl;
    logic        w_data_wr;
    logic        w_flush;
    logic        w_err_clr;
    logic        w_len_ok;
    logic        w_legal;
    logic        w_illegal;
    logic [6:0]  w_rem;
    logic [63:0] w_sreg_sh;
    logic [63:0] w_refill;
    logic        w_pop;
    logic        w_push;
    logic [6:0]  w_cnt_nxt;
    logic [63:0] w_sreg_nxt;
    logic [31:0] w_status;
    logic        w_ack_nxt;
    logic [31:0] w_dat_nxt;
    logic        w_unused_adr;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (AW+1)'(DEPTH));

    // A request is only taken while ack is low, so a held strobe acks once.
    assign w_req        = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_sel_ctrl   = wbs_adr_i[2];
    assign w_data_wr    = w_req & wbs_we_i & ~w_sel_ctrl;
    assign w_flush      = w_req & wbs_we_i & w_sel_ctrl & wbs_dat_i[0];
    assign w_err_clr    = w_req & wbs_we_i & w_sel_ctrl & wbs_dat_i[1];
    assign w_unused_adr = ^{wbs_adr_i[31:3], wbs_adr_i[1:0]};

    assign w_len_ok  = (consume_len_i != 5'd0) && (consume_len_i <= 5'd16) &&
                       ({2'b00, consume_len_i} <= r_bit_cnt);
    assign w_legal   = consume_en_i & w_len_ok & ~w_flush;
    assign w_illegal = consume_en_i & ~w_len_ok & ~w_flush;

    assign w_rem     = w_legal ? (r_bit_cnt - {2'b00, consume_len_i}) : r_bit_cnt;
    assign w_sreg_sh = w_legal ? (r_sreg << consume_len_i) : r_sreg;

    // Bits below the valid count are zero, so the refill word can simply be OR-ed in.
    assign w_refill   = {r_mem[r_rd_ptr[AW-1:0]], 32'h0} >> w_rem;
    assign w_pop      = ~w_flush & ~w_empty & (w_rem <= 7'd32);
    assign w_push     = w_data_wr & (~w_full | w_pop);
    assign w_cnt_nxt  = w_pop ? (w_rem + 7'd32) : w_rem;
    assign w_sreg_nxt = w_pop ? (w_sreg_sh | w_refill) : w_sreg_sh;

    assign w_status  = {14'h0, w_full, r_err, 4'h0, 4'(w_count), 1'b0, r_bit_cnt};
    assign w_ack_nxt = w_req & (~w_data_wr | w_push);
    assign w_dat_nxt = (w_ack_nxt & ~wbs_we_i & w_sel_ctrl) ? w_status : 32'h0;

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_err       <= 1'b0;
            r_win_valid <= 1'b0;
        end else begin
            r_ack <= w_ack_nxt;
            r_dat <= w_dat_nxt;
            r_err <= (r_err & ~w_err_clr) | w_illegal;
            if (w_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_sreg      <= '0;
                r_bit_cnt   <= '0;
                r_win_valid <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_sreg      <= w_sreg_nxt;
                r_bit_cnt   <= w_cnt_nxt;
                r_win_valid <= (w_cnt_nxt >= 7'd16);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wbs_dat_i;
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign win_o       = r_sreg[63:48];
    assign win_valid_o = r_win_valid;
    assign err_o       = r_err;
endmodule

// File: tb/tb_egd_bitstream_buffer.sv
// Bench for egd_bitstream_buffer: directed scenarios plus random bus/consume traffic,
// all checked every cycle against a bit-queue reference model.
module tb_egd_bitstream_buffer;
    localparam int DEPTH = 4;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] win_o;
    logic        win_valid_o;
    logic        consume_en_i;
    logic [4:0]  consume_len_i;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: word queue for the FIFO, bit queue for the shift register
    logic [31:0] mq_fifo[$];
    bit          mq_bits[$];
    logic        m_ack;
    logic [31:0] m_dat;
    logic        m_err;

    logic [31:0] bp [7];
    logic        acked;

    always #5 wb_clk_i = ~wb_clk_i;

    egd_bitstream_buffer #(.DEPTH(DEPTH)) dut (
        .wb_clk_i      (wb_clk_i),
        .rst_n         (rst_n),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .win_o         (win_o),
        .win_valid_o   (win_valid_o),
        .consume_en_i  (consume_en_i),
        .consume_len_i (consume_len_i),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] m_win();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++)
            if (i < mq_bits.size()) w[15-i] = mq_bits[i];
        return w;
    endfunction

    task automatic model_reset();
        mq_fifo.delete();
        mq_bits.delete();
        m_ack = 1'b0;
        m_dat = '0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit          req, data_wr, flush, clr, legal, illegal, popped, pushed, ack_n;
        logic [31:0] stat, w;
        int          fsz;
        if (!rst_n) begin
            model_reset();
            return;
        end
        req     = wbs_stb_i && wbs_cyc_i && !m_ack;
        data_wr = req && wbs_we_i && !wbs_adr_i[2];
        flush   = req && wbs_we_i && wbs_adr_i[2] && wbs_dat_i[0];
        clr     = req && wbs_we_i && wbs_adr_i[2] && wbs_dat_i[1];
        fsz     = mq_fifo.size();
        stat        = '0;
        stat[6:0]   = 7'(mq_bits.size());
        stat[11:8]  = 4'(fsz);
        stat[16]    = m_err;
        stat[17]    = (fsz == DEPTH);
        legal   = consume_en_i && consume_len_i >= 1 && consume_len_i <= 16 &&
                  int'(consume_len_i) <= mq_bits.size();
        illegal = consume_en_i && !legal && !flush;
        popped  = 0;
        pushed  = 0;
        if (flush) begin
            mq_fifo.delete();
            mq_bits.delete();
        end else begin
            if (legal) repeat (int'(consume_len_i)) void'(mq_bits.pop_front());
            if (fsz > 0 && mq_bits.size() <= 32) begin
                w = mq_fifo.pop_front();
                for (int i = 31; i >= 0; i--) mq_bits.push_back(w[i]);
                popped = 1;
            end
        end
        if (data_wr && (fsz < DEPTH || popped)) begin
            mq_fifo.push_back(wbs_dat_i);
            pushed = 1;
        end
        ack_n = req && (!data_wr || pushed);
        m_dat = (ack_n && !wbs_we_i && wbs_adr_i[2]) ? stat : 32'h0;
        m_ack = ack_n;
        m_err = (m_err && !clr) || illegal;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge wb_clk_i);
        chk("ack",   32'(wbs_ack_o), 32'(m_ack));
        chk("dat",   wbs_dat_o, m_dat);
        chk("win",   32'(win_o), 32'(m_win()));
        chk("valid", 32'(win_valid_o), 32'(mq_bits.size() >= 16));
        chk("err",   32'(err_o), 32'(m_err));
        @(posedge wb_clk_i);
        model_step();
        #1;
    endtask

    task automatic bus_xfer(input logic we_v, input logic [31:0] adr_v, input logic [31:0] dat_v);
        bit done;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we_v; wbs_adr_i = adr_v; wbs_dat_i = dat_v;
        done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            tick();
            if (m_ack) done = 1;
        end
        if (!done) chk("xfer_timeout", 32'(done), 32'd1);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    endtask

    task automatic start_random();
        int r;
        r = int'($urandom_range(0, 99));
        wbs_stb_i = 1; wbs_cyc_i = 1;
        wbs_dat_i = $urandom;
        if (r < 70) begin
            wbs_we_i = 1; wbs_adr_i = 32'h0;
        end else if (r < 80) begin
            wbs_we_i = 0; wbs_adr_i = 32'h4;
        end else if (r < 85) begin
            wbs_we_i = 0; wbs_adr_i = 32'h0;
        end else if (r < 96) begin
            wbs_we_i = 1; wbs_adr_i = 32'h4; wbs_dat_i = (wbs_dat_i & ~32'h3) | 32'h2;
        end else begin
            wbs_we_i = 1; wbs_adr_i = 32'h4; wbs_dat_i = wbs_dat_i | 32'h1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'hDEADBEEF;
        consume_en_i = 0; consume_len_i = 0;
        repeat (2) @(posedge wb_clk_i);
        model_reset();
        #1;
        chk("rst_ack",   32'(wbs_ack_o), 32'd0);
        chk("rst_valid", 32'(win_valid_o), 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_win",   32'(win_o), 32'd0);
        rst_n = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        bus_xfer(0, 32'h4, 32'h0);
        chk("rst_status", wbs_dat_o, 32'h0);

        // single word and consumes
        bus_xfer(1, 32'h0, 32'hA5A51234);
        chk("sw_ack", 32'(wbs_ack_o), 32'd1);
        tick();
        chk("sw_win",   32'(win_o), 32'h0000A5A5);
        chk("sw_valid", 32'(win_valid_o), 32'd1);
        consume_en_i = 1; consume_len_i = 5'd4; tick(); consume_en_i = 0;
        chk("sw_c4", 32'(win_o), 32'h00005A51);
        consume_en_i = 1; consume_len_i = 5'd16; tick(); consume_en_i = 0;
        chk("sw_c16_win",   32'(win_o), 32'h00002340);
        chk("sw_c16_valid", 32'(win_valid_o), 32'd0);

        // error: overlong consume, clear, zero-length consume
        consume_en_i = 1; consume_len_i = 5'd13; tick(); consume_en_i = 0;
        chk("er_set", 32'(err_o), 32'd1);
        chk("er_noshift", 32'(win_o), 32'h00002340);
        bus_xfer(0, 32'h4, 32'h0);
        chk("er_status", wbs_dat_o, 32'h0001000C);
        bus_xfer(1, 32'h4, 32'h2);
        chk("er_clr", 32'(err_o), 32'd0);
        consume_en_i = 1; consume_len_i = 5'd0; tick(); consume_en_i = 0;
        chk("er_len0", 32'(err_o), 32'd1);

        // word boundary
        bus_xfer(1, 32'h4, 32'h3);
        bus_xfer(1, 32'h0, 32'h0000FFFF);
        bus_xfer(1, 32'h0, 32'h80000000);
        repeat (2) tick();
        consume_en_i = 1; consume_len_i = 5'd16; tick();
        consume_len_i = 5'd15; tick(); consume_en_i = 0;
        chk("wb_win", 32'(win_o), 32'h0000C000);

        // back-pressure and ordering
        bus_xfer(1, 32'h4, 32'h3);
        for (int i = 0; i < 7; i++) bp[i] = $urandom;
        for (int i = 0; i < DEPTH + 2; i++) bus_xfer(1, 32'h0, bp[i]);
        bus_xfer(0, 32'h4, 32'h0);
        chk("bp_status", wbs_dat_o, 32'h00020000 | 32'(DEPTH << 8) | 32'd64);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h0; wbs_dat_i = bp[DEPTH+2];
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_stall", 32'(wbs_ack_o), 32'd0);
        end
        acked = 0;
        for (int k = 0; k < 14; k++) begin
            logic [31:0] wd;
            wd = bp[k/2];
            chk("bp_order", 32'(win_o), (k % 2 == 0) ? 32'(wd[31:16]) : 32'(wd[15:0]));
            consume_en_i = 1; consume_len_i = 5'd16;
            tick();
            if (wbs_stb_i && m_ack) begin
                acked = 1;
                wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
            end
        end
        consume_en_i = 0;
        chk("bp_acked", 32'(acked), 32'd1);

        // flush with queued words and a same-cycle consume
        bus_xfer(1, 32'h4, 32'h3);
        for (int i = 0; i < 5; i++) bus_xfer(1, 32'h0, $urandom);
        consume_en_i = 1; consume_len_i = 5'd0; tick();
        consume_len_i = 5'd4;
        bus_xfer(1, 32'h4, 32'h1);
        consume_en_i = 0;
        chk("fl_win",   32'(win_o), 32'h0);
        chk("fl_valid", 32'(win_valid_o), 32'd0);
        chk("fl_err",   32'(err_o), 32'd1);
        bus_xfer(0, 32'h4, 32'h0);
        chk("fl_status", wbs_dat_o, 32'h00010000);

        // random traffic with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 0; wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h0;
                repeat (2) tick();
                rst_n = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
            end
            consume_en_i  = ($urandom_range(0, 3) != 0);
            consume_len_i = ($urandom_range(0, 4) != 0) ? 5'($urandom_range(1, 16))
                                                        : 5'($urandom_range(0, 31));
            tick();
            if (wbs_stb_i && m_ack) begin
                wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
            end else if (!wbs_stb_i && $urandom_range(0, 2) != 0) begin
                start_random();
            end
        end
        consume_en_i = 0;
        wbs_stb_i = 0; wbs_cyc_i = 0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
